fpu_dseq: RTL

- Sequencer for the double-precision FPU datapath: the adder, multiplier, FP64-to-int converter and int-to-FP64 converter.
- Accepts one FPU command at a time from decode over a valid/ready handshake.
- Enables the correct multi-cycle unit, counts its fixed latency and chains MAC/MSC as multiply-then-add. Compares resolve locally.
- Returns one result to writeback, or one T-bit update to SR, per command. The pipeline stalls on busy.

---
 rtl/fpu_dseq_if.sv | 47 ++++
 rtl/fpu_dseq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_dseq_if.sv
// Command, unit-control, writeback and status bundle shared by decode, the FPU units
// and the double-precision sequencer.
interface fpu_dseq_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [7:0]  cmdOp;
  logic [6:0]  cmdRegD;
  logic [63:0] cmdValA;
  logic [63:0] cmdValB;
  logic [63:0] cmdValC;
  logic        flush;
  logic        addEn;
  logic        addIsSub;
  logic [63:0] addSrcA;
  logic [63:0] addSrcB;
  logic [63:0] addDst;
  logic        mulEn;
  logic [63:0] mulSrcA;
  logic [63:0] mulSrcB;
  logic [63:0] mulDst;
  logic        cnvEn;
  logic        cnvToInt;
  logic [63:0] cnvSrc;
  logic [63:0] cnvDstI;
  logic [63:0] cnvDstF;
  logic        wbValid;
  logic [6:0]  wbReg;
  logic [63:0] wbVal;
  logic        srTValid;
  logic        srT;
  logic        busy;

  // Decode and the arithmetic units together form the master side.
  modport master (
    output cmdValid, cmdOp, cmdRegD, cmdValA, cmdValB, cmdValC, flush,
           addDst, mulDst, cnvDstI, cnvDstF,
    input  cmdReady, addEn, addIsSub, addSrcA, addSrcB, mulEn, mulSrcA, mulSrcB,
           cnvEn, cnvToInt, cnvSrc, wbValid, wbReg, wbVal, srTValid, srT, busy
  );

  modport slave (
    input  cmdValid, cmdOp, cmdRegD, cmdValA, cmdValB, cmdValC, flush,
           addDst, mulDst, cnvDstI, cnvDstF,
    output cmdReady, addEn, addIsSub, addSrcA, addSrcB, mulEn, mulSrcA, mulSrcB,
           cnvEn, cnvToInt, cnvSrc, wbValid, wbReg, wbVal, srTValid, srT, busy
  );
endinterface

// File: rtl/fpu_dseq.sv
// FP64 command sequencer: runs one command at a time through the adder, multiplier or
// converter, chains MAC/MSC as multiply-then-add, and resolves compares locally.
module fpu_dseq #(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 3,
  parameter int CNV_LAT = 2
) (
  input logic       clk,
  input logic       rst_n,
  fpu_dseq_if.slave bus
);
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_MUL   = 8'h03;
  localparam logic [7:0] OP_MAC   = 8'h04;
  localparam logic [7:0] OP_MSC   = 8'h05;
  localparam logic [7:0] OP_CNVSI = 8'h06;
  localparam logic [7:0] OP_CNVIS = 8'h07;
  localparam logic [7:0] OP_ABS   = 8'h08;
  localparam logic [7:0] OP_NEG   = 8'h09;
  localparam logic [7:0] OP_MOV   = 8'h0A;
  localparam logic [7:0] OP_CNVSD = 8'h0B;
  localparam logic [7:0] OP_CMPEQ = 8'h0C;
  localparam logic [7:0] OP_CMPGT = 8'h0D;

  localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] CNV_CNT = 4'(CNV_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_CNV, S_WB} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  op;
  logic [63:0] val_c;

  // Sign-magnitude ordering; mixed signs decide on the sign bit alone.
  function automatic logic cmp_gt(input logic [63:0] a, input logic [63:0] b);
    case ({a[63], b[63]})
      2'b00:   return a[62:0] > b[62:0];
      2'b11:   return a[62:0] < b[62:0];
      2'b01:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      op           <= '0;
      val_c        <= '0;
      bus.cmdReady <= 1'b1;
      bus.busy     <= 1'b0;
      bus.addEn    <= 1'b0;
      bus.addIsSub <= 1'b0;
      bus.addSrcA  <= '0;
      bus.addSrcB  <= '0;
      bus.mulEn    <= 1'b0;
      bus.mulSrcA  <= '0;
      bus.mulSrcB  <= '0;
      bus.cnvEn    <= 1'b0;
      bus.cnvToInt <= 1'b0;
      bus.cnvSrc   <= '0;
      bus.wbValid  <= 1'b0;
      bus.wbReg    <= '0;
      bus.wbVal    <= '0;
      bus.srTValid <= 1'b0;
      bus.srT      <= 1'b0;
    end else begin
      bus.wbValid  <= 1'b0;
      bus.srTValid <= 1'b0;
      if (bus.flush) begin
        state        <= S_IDLE;
        cnt          <= '0;
        bus.addEn    <= 1'b0;
        bus.mulEn    <= 1'b0;
        bus.cnvEn    <= 1'b0;
        bus.cmdReady <= 1'b1;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.cmdValid && bus.cmdReady) begin
              op        <= bus.cmdOp;
              val_c     <= bus.cmdValC;
              bus.wbReg <= bus.cmdRegD;
              case (bus.cmdOp)
                OP_ADD, OP_SUB: begin
                  state        <= S_ADD;
                  cnt          <= ADD_CNT;
                  bus.addEn    <= 1'b1;
                  bus.addIsSub <= (bus.cmdOp == OP_SUB);
                  bus.addSrcA  <= bus.cmdValA;
                  bus.addSrcB  <= bus.cmdValB;
                  bus.busy     <= 1'b1;
                  bus.cmdReady <= 1'b0;
                end
                OP_MUL, OP_MAC, OP_MSC: begin
                  state        <= S_MUL;
                  cnt          <= MUL_CNT;
                  bus.mulEn    <= 1'b1;
                  bus.mulSrcA  <= bus.cmdValA;
                  bus.mulSrcB  <= bus.cmdValB;
                  bus.busy     <= 1'b1;
                  bus.cmdReady <= 1'b0;
                end
                OP_CNVSI, OP_CNVIS: begin
                  state        <= S_CNV;
                  cnt          <= CNV_CNT;
                  bus.cnvEn    <= 1'b1;
                  bus.cnvToInt <= (bus.cmdOp == OP_CNVSI);
                  bus.cnvSrc   <= bus.cmdValB;
                  bus.busy     <= 1'b1;
                  bus.cmdReady <= 1'b0;
                end
                OP_ABS, OP_NEG, OP_MOV, OP_CNVSD: begin
                  state        <= S_WB;
                  bus.wbValid  <= 1'b1;
                  bus.busy     <= 1'b1;
                  bus.cmdReady <= 1'b0;
                  if (bus.cmdOp == OP_ABS)
                    bus.wbVal <= {1'b0, bus.cmdValB[62:0]};
                  else if (bus.cmdOp == OP_NEG)
                    bus.wbVal <= {~bus.cmdValB[63], bus.cmdValB[62:0]};
                  else
                    bus.wbVal <= bus.cmdValB;
                end
                OP_CMPEQ: begin
                  bus.srTValid <= 1'b1;
                  bus.srT      <= (bus.cmdValA == bus.cmdValB);
                end
                OP_CMPGT: begin
                  bus.srTValid <= 1'b1;
                  bus.srT      <= cmp_gt(bus.cmdValA, bus.cmdValB);
                end
                default: ;
              endcase
            end
          end
          S_MUL: begin
            if (cnt == 4'd0) begin
              bus.mulEn <= 1'b0;
              if (op == OP_MUL) begin
                state       <= S_WB;
                bus.wbValid <= 1'b1;
                bus.wbVal   <= bus.mulDst;
              end else begin
                // MAC/MSC: accumulate C with the freshly produced product.
                state        <= S_ADD;
                cnt          <= ADD_CNT;
                bus.addEn    <= 1'b1;
                bus.addIsSub <= (op == OP_MSC);
                bus.addSrcA  <= val_c;
                bus.addSrcB  <= bus.mulDst;
              end
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_ADD: begin
            if (cnt == 4'd0) begin
              state       <= S_WB;
              bus.addEn   <= 1'b0;
              bus.wbValid <= 1'b1;
              bus.wbVal   <= bus.addDst;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_CNV: begin
            if (cnt == 4'd0) begin
              state       <= S_WB;
              bus.cnvEn   <= 1'b0;
              bus.wbValid <= 1'b1;
              bus.wbVal   <= bus.cnvToInt ? bus.cnvDstI : bus.cnvDstF;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          S_WB: begin
            state        <= S_IDLE;
            bus.busy     <= 1'b0;
            bus.cmdReady <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
